// File: rtl/unum4_unpack.sv
// unum4 unpack unit: splits a packed unum4 word into a sign-extended exponent
// and a normalised two's-complement mantissa, over a 3-stage valid/ready pipeline.
module unum4_unpack #(
  parameter int DATA_W    = 32,
  parameter int MAN_MAX_W = 29,
  parameter int EXP_SZ_W  = 4,
  parameter int EXP_MAX_W = 16,
  parameter int EXTRA     = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_MAX_W-1:0]       exp,
  output logic [MAN_MAX_W+EXTRA-1:0] mant,
  output logic                       zero
);

  localparam int BODY_W = DATA_W - EXP_SZ_W;
  localparam int ES_MAX = BODY_W - 1;
  localparam int EF_W   = ES_MAX;
  localparam int ML_W   = MAN_MAX_W - 1;

  logic                       advance;

  logic                       s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]          s1_word_q, s1_word_d;

  logic                       s2_valid_q, s2_valid_d;
  logic [MAN_MAX_W-1:0]       s2_man_q, s2_man_d;
  logic [EF_W-1:0]            s2_ef_q, s2_ef_d;
  logic [EXP_SZ_W-1:0]        s2_es_q, s2_es_d;
  logic                       s2_zero_q, s2_zero_d;

  logic                       out_valid_q, out_valid_d;
  logic [EXP_MAX_W-1:0]       exp_q, exp_d;
  logic [MAN_MAX_W+EXTRA-1:0] mant_q, mant_d;
  logic                       zero_q, zero_d;

  logic [EXP_SZ_W-1:0]        es_raw, es_sat;
  logic [BODY_W-1:0]          body;
  logic [ML_W-1:0]            man_low;
  logic [MAN_MAX_W-1:0]       dec_man;
  logic [EF_W-1:0]            dec_ef;

  logic                       sign;
  logic [EXP_MAX_W-1:0]       ef_pad;
  logic [EXP_MAX_W-1:0]       e_ext;
  logic [EXP_MAX_W-1:0]       exp_restored;

  // Stage 1 may refill into an empty slot even while the rest of the pipe is stalled.
  always_comb begin
    advance  = ~out_valid_q | out_ready;
    in_ready = ~s1_valid_q | advance;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_word_d  = s1_word_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_word_d = data_in;
      end
    end
  end

  // Decode: exponent-size saturation, mantissa barrel shift and exponent field extraction.
  always_comb begin
    es_raw = s1_word_q[EXP_SZ_W-1:0];
    es_sat = es_raw;
    if (int'(es_raw) > ES_MAX) begin
      es_sat = EXP_SZ_W'(ES_MAX);
    end
    body    = s1_word_q[DATA_W-1:EXP_SZ_W];
    man_low = ML_W'(body) << es_sat;
    if (es_sat == '0) begin
      dec_man = {body[BODY_W-1], man_low};
    end else begin
      dec_man = {~man_low[ML_W-1], man_low};
    end
    dec_ef = EF_W'(s1_word_q >> (DATA_W - int'(es_sat)));
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_man_d   = s2_man_q;
    s2_ef_d    = s2_ef_q;
    s2_es_d    = s2_es_q;
    s2_zero_d  = s2_zero_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s2_man_d   = dec_man;
      s2_ef_d    = dec_ef;
      s2_es_d    = es_sat;
      s2_zero_d  = (s1_word_q == '0);
    end
  end

  // Exponent restore: sign-extend from bit es-1, then add 1 to negatives.
  always_comb begin
    sign   = 1'b0;
    ef_pad = EXP_MAX_W'(s2_ef_q);
    e_ext  = '0;
    for (int i = 0; i < EF_W; i++) begin
      if (i == int'(s2_es_q) - 1) begin
        sign = s2_ef_q[i];
      end
    end
    for (int i = 0; i < EXP_MAX_W; i++) begin
      e_ext[i] = (i < int'(s2_es_q)) ? ef_pad[i] : sign;
    end
    exp_restored = e_ext + {{(EXP_MAX_W-1){1'b0}}, sign};
  end

  always_comb begin
    out_valid_d = out_valid_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    zero_d      = zero_q;
    if (advance) begin
      out_valid_d = s2_valid_q;
      exp_d       = exp_restored;
      mant_d      = {s2_man_q, {EXTRA{1'b0}}};
      zero_d      = s2_zero_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_word_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_man_q    <= '0;
      s2_ef_q     <= '0;
      s2_es_q     <= '0;
      s2_zero_q   <= 1'b0;
      out_valid_q <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_word_q   <= s1_word_d;
      s2_valid_q  <= s2_valid_d;
      s2_man_q    <= s2_man_d;
      s2_ef_q     <= s2_ef_d;
      s2_es_q     <= s2_es_d;
      s2_zero_q   <= s2_zero_d;
      out_valid_q <= out_valid_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign exp       = exp_q;
  assign mant      = mant_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_unum4_unpack.sv
// Self-checking bench for unum4_unpack: directed vectors, stall/backpressure,
// throughput, randomized streaming against an arithmetic reference model, and reset.
module tb_unum4_unpack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] exp;
  logic [31:0] mant;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_q[$];

  typedef struct packed {
    logic [15:0] e;
    logic [31:0] mant;
    logic        z;
  } ref_t;

  localparam logic [31:0] PLAN_W [4] = '{32'h00000000, 32'h40000000, 32'h50000003, 32'hD0000003};
  localparam logic [15:0] PLAN_E [4] = '{16'h0000, 16'h0000, 16'h0002, 16'hFFFF};
  localparam logic [31:0] PLAN_M [4] = '{32'h00000000, 32'h20000000, 32'h40000000, 32'h40000000};
  localparam logic        PLAN_Z [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  localparam logic [31:0] BND_W [7] = '{32'h0000000F, 32'hFFFFFFFF, 32'h8000000F, 32'h7FFF800F,
                                        32'h80000000, 32'h00000001, 32'h00000010};
  localparam logic [15:0] BND_E [7] = '{16'h0000, 16'h0000, 16'hC001, 16'h3FFF,
                                        16'h0000, 16'h0000, 16'h0000};
  localparam logic [31:0] BND_M [7] = '{32'h80000000, 32'h7FFC0000, 32'h80000000, 32'h60000000,
                                        32'hC0000000, 32'h80000000, 32'h00000008};

  unum4_unpack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp       (exp),
    .mant      (mant),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference model: decode with plain integer arithmetic.
  function automatic ref_t ref_model(input logic [31:0] w);
    ref_t r;
    int es;
    longint unsigned body, mlow, m, ef, ev;
    es = int'(w[3:0]);
    if (es > 27) es = 27;
    body = longint'(w >> 4);
    if (es == 0) begin
      m  = body + (((body >> 27) & 64'd1) << 28);
      ev = 64'd0;
    end else begin
      mlow = (body << es) % (64'd1 << 28);
      m    = mlow + ((((mlow >> 27) & 64'd1) == 64'd0) ? (64'd1 << 28) : 64'd0);
      ef   = longint'(w >> (32 - es));
      if (ef >= (64'd1 << (es - 1))) ev = ef - (64'd1 << es) + 64'd1;
      else                           ev = ef;
    end
    r.e    = ev[15:0];
    r.mant = 32'(m << 3);
    r.z    = (w == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return $urandom | 32'h0000000F;
      2:       return $urandom & 32'hFFFFFFF0;
      default: return $urandom;
    endcase
  endfunction

  // Drives one word into an idle pipe and waits (bounded) for its result.
  task automatic send_one(input logic [31:0] w, output bit rdy, output int edges,
                          output logic [15:0] e, output logic [31:0] m, output logic z);
    in_valid  = 1'b1;
    data_in   = w;
    out_ready = 1'b1;
    #1;
    rdy = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = '0;
    edges    = 0;
    while (!out_valid && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    e = exp;
    m = mant;
    z = zero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || exp !== 16'h0 || mant !== 32'h0 || zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: got v=%b e=%h m=%h z=%b expected all 0", out_valid, exp, mant, zero);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_plan_vectors();
    bit rdy; int edges; logic [15:0] e; logic [31:0] m; logic z;
    for (int i = 0; i < 4; i++) begin
      send_one(PLAN_W[i], rdy, edges, e, m, z);
      checks++;
      if (rdy !== 1'b1 || edges != 2) begin
        failures++;
        $display("[TB] FAIL plan_latency[%0d]: got ready=%b edges=%0d expected 1/2", i, rdy, edges);
      end
      checks++;
      if (e !== PLAN_E[i] || m !== PLAN_M[i] || z !== PLAN_Z[i]) begin
        failures++;
        $display("[TB] FAIL plan_data[%0d]: got e=%h m=%h z=%b expected e=%h m=%h z=%b",
                 i, e, m, z, PLAN_E[i], PLAN_M[i], PLAN_Z[i]);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL plan_single[%0d]: got out_valid=%b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_boundary_words();
    bit rdy; int edges; logic [15:0] e; logic [31:0] m; logic z;
    for (int i = 0; i < 7; i++) begin
      send_one(BND_W[i], rdy, edges, e, m, z);
      checks++;
      if (edges != 2 || e !== BND_E[i] || m !== BND_M[i] || z !== 1'b0) begin
        failures++;
        $display("[TB] FAIL boundary[%0d] w=%h: got edges=%0d e=%h m=%h z=%b expected 2 e=%h m=%h z=0",
                 i, BND_W[i], edges, e, m, z, BND_E[i], BND_M[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    int sent, got, stall_left, cyc;
    bit first_seen, stalled_prev, saw_low, exp_rdy, acc, cons;
    logic [15:0] se; logic [31:0] sm; logic sz;
    logic [31:0] wexp; ref_t r;
    for (int i = 0; i < 4; i++) w[i] = rand_word();
    sb_q.delete();
    sent = 0; got = 0; stall_left = 0; cyc = 0;
    first_seen = 0; stalled_prev = 0; saw_low = 0;
    se = '0; sm = '0; sz = 1'b0;
    while (got < 4 && cyc < 60) begin
      if (out_valid && !first_seen) begin
        first_seen = 1;
        stall_left = 5;
      end
      out_ready = !(stall_left > 0);
      in_valid  = (sent < 4);
      data_in   = (sent < 4) ? w[sent] : 32'd0;
      #1;
      if (stalled_prev) begin
        checks++;
        if (out_valid !== 1'b1 || exp !== se || mant !== sm || zero !== sz) begin
          failures++;
          $display("[TB] FAIL b2b_hold: got v=%b e=%h m=%h z=%b expected 1 e=%h m=%h z=%b",
                   out_valid, exp, mant, zero, se, sm, sz);
        end
      end
      exp_rdy = !(sb_q.size() == 3 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("[TB] FAIL b2b_in_ready: got %b expected %b (buffered=%0d)", in_ready, exp_rdy, sb_q.size());
      end
      if (!in_ready) saw_low = 1;
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL b2b_spurious: got output e=%h m=%h expected none", exp, mant);
        end else begin
          wexp = sb_q.pop_front();
          r = ref_model(wexp);
          if (exp !== r.e || mant !== r.mant || zero !== r.z) begin
            failures++;
            $display("[TB] FAIL b2b_data w=%h: got e=%h m=%h z=%b expected e=%h m=%h z=%b",
                     wexp, exp, mant, zero, r.e, r.mant, r.z);
          end
        end
        got++;
      end
      if (acc) begin
        sb_q.push_back(data_in);
        sent++;
      end
      stalled_prev = out_valid && !out_ready;
      se = exp; sm = mant; sz = zero;
      if (stall_left > 0) stall_left--;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4 || sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d results (%0d pending) expected 4 (0)", got, sb_q.size());
    end
    checks++;
    if (!saw_low) begin
      failures++;
      $display("[TB] FAIL b2b_backpressure: got in_ready never low expected low while stalled");
    end
  endtask

  task automatic test_throughput();
    logic [31:0] wexp; ref_t r; bit exp_ov;
    sb_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      in_valid = (c < 20);
      data_in  = (c < 20) ? rand_word() : 32'd0;
      #1;
      exp_ov = (c >= 3 && c < 23);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== exp_ov) begin
        failures++;
        $display("[TB] FAIL tput_cycle[%0d]: got in_ready=%b out_valid=%b expected 1/%b", c, in_ready, out_valid, exp_ov);
      end
      if (out_valid && sb_q.size() > 0) begin
        wexp = sb_q.pop_front();
        r = ref_model(wexp);
        checks++;
        if (exp !== r.e || mant !== r.mant || zero !== r.z) begin
          failures++;
          $display("[TB] FAIL tput_data w=%h: got e=%h m=%h z=%b expected e=%h m=%h z=%b",
                   wexp, exp, mant, zero, r.e, r.mant, r.z);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(data_in);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random_stream();
    logic [31:0] wexp; ref_t r;
    bit acc, cons, stalled_prev;
    logic [15:0] se; logic [31:0] sm; logic sz;
    int drain;
    sb_q.delete();
    in_valid = 1'b0; out_ready = 1'b0; stalled_prev = 0;
    se = '0; sm = '0; sz = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        data_in  = rand_word();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled_prev) begin
        checks++;
        if (out_valid !== 1'b1 || exp !== se || mant !== sm || zero !== sz) begin
          failures++;
          $display("[TB] FAIL rand_hold: got v=%b e=%h m=%h z=%b expected 1 e=%h m=%h z=%b",
                   out_valid, exp, mant, zero, se, sm, sz);
        end
      end
      if (sb_q.size() == 0) begin
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL rand_empty: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
      end
      if (sb_q.size() == 3 && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL rand_full: got in_ready=%b expected 0", in_ready);
        end
      end
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons && sb_q.size() > 0) begin
        wexp = sb_q.pop_front();
        r = ref_model(wexp);
        checks++;
        if (exp !== r.e || mant !== r.mant || zero !== r.z) begin
          failures++;
          $display("[TB] FAIL rand_data w=%h: got e=%h m=%h z=%b expected e=%h m=%h z=%b",
                   wexp, exp, mant, zero, r.e, r.mant, r.z);
        end
      end
      if (acc) sb_q.push_back(data_in);
      stalled_prev = out_valid && !out_ready;
      se = exp; sm = mant; sz = zero;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1; drain = 0;
    while (sb_q.size() > 0 && drain < 12) begin
      #1;
      if (out_valid) begin
        wexp = sb_q.pop_front();
        r = ref_model(wexp);
        checks++;
        if (exp !== r.e || mant !== r.mant || zero !== r.z) begin
          failures++;
          $display("[TB] FAIL rand_drain_data w=%h: got e=%h m=%h expected e=%h m=%h", wexp, exp, mant, r.e, r.mant);
        end
      end
      @(posedge clk); #1;
      drain++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL rand_lost: got %0d words undelivered expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid_stream();
    bit rdy; int edges; logic [15:0] e; logic [31:0] m; logic z;
    logic [31:0] w2; ref_t r;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'h50000003;
    @(posedge clk); #1;
    data_in = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = '0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || exp !== 16'h0002) begin
      failures++;
      $display("[TB] FAIL rst_pre: got out_valid=%b exp=%h expected 1/0002", out_valid, exp);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || exp !== 16'h0 || mant !== 32'h0 || zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_async: got v=%b e=%h m=%h z=%b expected all 0", out_valid, exp, mant, zero);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || (i == 0 && in_ready !== 1'b1)) begin
        failures++;
        $display("[TB] FAIL rst_stale[%0d]: got out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
      end
    end
    w2 = rand_word();
    r  = ref_model(w2);
    send_one(w2, rdy, edges, e, m, z);
    checks++;
    if (rdy !== 1'b1 || edges != 2 || e !== r.e || m !== r.mant || z !== r.z) begin
      failures++;
      $display("[TB] FAIL rst_after w=%h: got rdy=%b edges=%0d e=%h m=%h z=%b expected 1 2 e=%h m=%h z=%b",
               w2, rdy, edges, e, m, z, r.e, r.mant, r.z);
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_boundary_words();
    test_back_to_back();
    test_throughput();
    test_random_stream();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: got simulation timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
